// File: rtl/systolic_drain.sv
// systolic_drain: captures a diagonally skewed N x N result tile from the systolic array and streams it out row by row.
module systolic_drain #(
  parameter int N = 4,
  parameter int W = 16,
  parameter int ROW_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N*W-1:0]   col_data,
  output logic [N-1:0]     cap_mask,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*W-1:0]   out_data,
  output logic [ROW_W-1:0] out_row,
  output logic             out_last
);
  localparam int KW = $clog2(2 * N);
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
  state_t state;
  logic [KW-1:0] cnt;
  logic [KW-1:0] cnt_next;
  logic [ROW_W:0] ptr;
  logic [ROW_W-1:0] cur;
  logic [ROW_W-1:0] fin_row;
  logic [N-1:0] done;
  logic [N-1:0] next_mask;
  logic [N*W-1:0] row_data;
  logic [W-1:0] buffer [N][N];
  logic completing;
  logic avail;
  logic load;
  logic last_hs;
  // The last column of a row lands on the same edge the row may be presented, so it is bypassed from col_data.
  always_comb begin
    cnt_next = cnt + 1'b1;
    fin_row = ROW_W'(cnt - KW'(N - 1));
    cur = ptr[ROW_W-1:0];
    completing = cap_mask[N-1] && fin_row == cur;
    avail = !ptr[ROW_W] && (done[cur] || completing);
    load = !out_valid || out_ready;
    last_hs = out_valid && out_ready && out_last;
    for (int j = 0; j < N; j++) begin
      next_mask[j] = int'(cnt_next) >= j && int'(cnt_next) < j + N;
      row_data[j*W +: W] = (j == N - 1 && completing) ? col_data[j*W +: W] : buffer[cur][j];
    end
  end
  always_ff @(posedge clock)
    for (int j = 0; j < N; j++)
      if (cap_mask[j]) buffer[ROW_W'(cnt - KW'(j))][j] <= col_data[j*W +: W];
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      cap_mask <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_row <= '0;
      out_last <= 1'b0;
      done <= '0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= CAPTURE;
        busy <= 1'b1;
        cnt <= '0;
        cap_mask <= N'(1);
        done <= '0;
        ptr <= '0;
      end
    end else begin
      if (cap_mask[N-1]) done[fin_row] <= 1'b1;
      if (state == CAPTURE) begin
        if (cnt == KW'(2 * N - 2)) begin
          state <= DRAIN;
          cnt <= KW'(2 * N - 1);
          cap_mask <= '0;
        end else begin
          cnt <= cnt_next;
          cap_mask <= next_mask;
        end
      end
      if (load) begin
        out_valid <= avail;
        out_last <= avail && cur == ROW_W'(N - 1);
        if (avail) begin
          out_data <= row_data;
          out_row <= cur;
          ptr <= ptr + 1'b1;
        end
      end
      if (last_hs) begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: random and directed tiles against a tile-level model of the drain controller, plus an N=2 instance.
module tb_systolic_drain;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [63:0] col_data = '0;
  logic out_ready = 1'b0;
  logic [3:0] cap_mask;
  logic busy, out_valid, out_last;
  logic [63:0] out_data;
  logic [1:0] out_row;
  logic start2 = 1'b0;
  logic [31:0] col2 = '0;
  logic ready2 = 1'b1;
  logic [1:0] cap_mask2;
  logic busy2, out_valid2, out_last2;
  logic [31:0] out_data2;
  logic [0:0] out_row2;
  systolic_drain #(.N(4), .W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .col_data(col_data),
    .cap_mask(cap_mask), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last)
  );
  systolic_drain #(.N(2), .W(16)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .col_data(col2),
    .cap_mask(cap_mask2), .busy(busy2), .out_valid(out_valid2), .out_ready(ready2),
    .out_data(out_data2), .out_row(out_row2), .out_last(out_last2)
  );
  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Tile-level model: m_k counts edges since start, m_acc counts accepted rows.
  bit m_busy = 0;
  int m_k = 0;
  int m_acc = 0;
  logic [15:0] tile [4][4];
  initial forever begin
    @(posedge clock);
    if (!reset) begin
      m_busy = 0; m_k = 0; m_acc = 0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1; m_k = 0; m_acc = 0; end
    end else begin
      for (int j = 0; j < 4; j++)
        if (m_k >= j && m_k < j + 4) tile[m_k-j][j] = col_data[j*16 +: 16];
      if (m_acc < 4 && m_k >= m_acc + 4 && out_ready) m_acc++;
      m_k++;
      if (m_acc == 4) m_busy = 0;
    end
  end
  initial forever begin
    logic [3:0] em;
    logic [63:0] ed;
    bit ev;
    @(negedge clock);
    for (int j = 0; j < 4; j++) em[j] = m_busy && m_k >= j && m_k < j + 4;
    ev = m_busy && m_acc < 4 && m_k >= m_acc + 4;
    chk("cap_mask", 64'(cap_mask), 64'(em));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      for (int j = 0; j < 4; j++) ed[j*16 +: 16] = tile[m_acc][j];
      chk("out_data", out_data, ed);
      chk("out_row", 64'(out_row), 64'(m_acc));
      chk("out_last", 64'(out_last), 64'(m_acc == 3));
    end
    if (out_valid)
      for (int j = 0; j < 4; j++) chk("no_dead", 64'(out_data[j*16 +: 16] == 16'hDEAD), 64'(0));
  end
  logic [3:0] mt [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
  task automatic drive(input int k, input logic [15:0] base, input bit rnd);
    logic [15:0] v;
    for (int j = 0; j < 4; j++) begin
      v = 16'hDEAD;
      if (k >= j && k < j + 4) begin
        v = rnd ? 16'($urandom) : base + 16'(16 * (k - j) + j);
        if (v == 16'hDEAD) v = 16'hBEEF;
      end
      col_data[j*16 +: 16] = v;
    end
  endtask
  // Called at a negedge; start is sampled on the very next edge.
  task automatic run_tile(input int rmode, input logic [15:0] base, input bit rnd, input bit pin, input bit pokes);
    bit fin;
    int e;
    fin = 0;
    start = 1'b1;
    col_data = {4{16'hDEAD}};
    out_ready = rmode != 1;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge clock);
      start = pokes && k == 2;
      if (pin && k < 8) begin
        chk("pin_mask", 64'(cap_mask), 64'(mt[k]));
        chk("pin_valid", 64'(out_valid), 64'(k >= 4));
        if (k == 4) chk("pin_row0", out_data, 64'h0003_0002_0001_0000);
        if (k == 7) begin
          chk("pin_row3", out_data, 64'h0033_0032_0031_0030);
          chk("pin_last", 64'(out_last), 64'(1));
        end
      end
      if (pin && k == 8) chk("pin_busy_low", 64'(busy), 64'(0));
      drive(k, base, rnd);
      e = k + 1;
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (e >= 10 && (e - 10) % 2 == 0) : 1'($urandom_range(0, 1));
      if (pokes && out_valid && out_last && out_ready) start = 1'b1;
      if (k > 0 && !busy) fin = 1;
    end
    chk("tile_done", 64'(fin), 64'(1));
  endtask
  initial begin
    repeat (3) begin
      @(negedge clock);
      start = 1'($urandom_range(0, 1));
      col_data = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    chk("rst_mask", 64'(cap_mask), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", out_data, 64'(0));
    chk("rst_row", 64'(out_row), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    run_tile(0, 16'h0000, 0, 1, 0);
    run_tile(1, 16'h0100, 0, 0, 0);
    run_tile(0, 16'h0200, 0, 0, 1);
    run_tile(0, 16'h0300, 0, 0, 0);
    start = 1'b1;
    out_ready = 1'b1;
    col_data = {4{16'hDEAD}};
    @(negedge clock);
    start = 1'b0;
    drive(0, 16'h0500, 0);
    @(negedge clock);
    drive(1, 16'h0500, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    col_data = {4{16'hDEAD}};
    chk("mid_rst_mask", 64'(cap_mask), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_data", out_data, 64'(0));
    repeat (10) @(negedge clock);
    run_tile(0, 16'h0600, 0, 0, 0);
    for (int i = 0; i < 6; i++) run_tile(2, 16'h0000, 1, 0, i % 2 == 1);
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    col2 = {16'hDEAD, 16'hA000};
    chk("n2_mask0", 64'(cap_mask2), 64'(2'b01));
    chk("n2_busy0", 64'(busy2), 64'(1));
    @(negedge clock);
    chk("n2_mask1", 64'(cap_mask2), 64'(2'b11));
    chk("n2_valid1", 64'(out_valid2), 64'(0));
    col2 = {16'hA001, 16'hA010};
    @(negedge clock);
    chk("n2_mask2", 64'(cap_mask2), 64'(2'b10));
    chk("n2_valid2", 64'(out_valid2), 64'(1));
    chk("n2_row0", 64'(out_data2), 64'h0000_0000_A001_A000);
    chk("n2_rowidx0", 64'(out_row2), 64'(0));
    chk("n2_last0", 64'(out_last2), 64'(0));
    col2 = {16'hA011, 16'hDEAD};
    @(negedge clock);
    chk("n2_mask3", 64'(cap_mask2), 64'(2'b00));
    chk("n2_valid3", 64'(out_valid2), 64'(1));
    chk("n2_row1", 64'(out_data2), 64'h0000_0000_A011_A010);
    chk("n2_rowidx1", 64'(out_row2), 64'(1));
    chk("n2_last1", 64'(out_last2), 64'(1));
    col2 = {16'hDEAD, 16'hDEAD};
    @(negedge clock);
    chk("n2_busy_low", 64'(busy2), 64'(0));
    chk("n2_valid_low", 64'(out_valid2), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
